// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// master drives start and operands; slave returns busy, done and product.
interface seq_shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier, one multiplier bit per clock through a single 2*WIDTH adder.
// Latency: done WIDTH+1 edges after the accepting edge; with SEQ_MUL_EARLY_TERM_EN, iterations+1 edges.
// Backpressure: start is only accepted while busy is low; a start seen while busy is dropped, not queued.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    seq_shift_add_multiplier_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FIN = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand_sh;
    logic [WIDTH-1:0]  mplier_sh;
    logic [CW-1:0]     count;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     product_q;
    logic [CW-1:0]     count_nxt;

    // count parks at FIN once the last iteration has run; the following edge publishes acc
    always_comb begin
        count_nxt = count + 1'b1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        if (mplier_sh[WIDTH-1:1] == '0) begin
            count_nxt = FIN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_sh  <= {{WIDTH{1'b0}}, bus.multiplicand};
                        mplier_sh <= bus.multiplier;
                        acc       <= '0;
                        count     <= '0;
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    if (count == FIN) begin
                        product_q <= acc;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        if (mplier_sh[0]) begin
                            acc <= acc + mcand_sh;
                        end
                        mcand_sh  <= mcand_sh << 1;
                        mplier_sh <= mplier_sh >> 1;
                        count     <= count_nxt;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier at WIDTH=8 and WIDTH=16.
// Stimulus pushes expected product and done edge; the monitor pops on each done.
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_shift_add_multiplier_if #(.WIDTH(8))  i8();
    seq_shift_add_multiplier_if #(.WIDTH(16)) i16();

    seq_shift_add_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    seq_shift_add_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [15:0] hold8;
    logic [31:0] hold16;

    function automatic void check(string name, bit ok, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    endfunction

    // edges from the accepting edge to the done edge
    function automatic int lat(int w, logic [31:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
        int it = 1;
        for (int i = 0; i < w; i++) if (b[i]) it = i + 1;
        return it + 1;
`else
        return w + 1;
`endif
    endfunction

    // monitor: sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst_n) begin
            hold8  = '0;
            hold16 = '0;
        end else begin
            if (i8.done) begin
                check("w8_busy_with_done", i8.busy == 1'b0, i8.busy, 0);
                check("w8_done_expected", q8.size() != 0, q8.size(), 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("w8_product", i8.product == e.prod[15:0], i8.product, e.prod);
                    check("w8_done_edge", cyc == e.cyc, cyc, e.cyc);
                    hold8 = e.prod[15:0];
                end
            end else begin
                check("w8_product_hold", i8.product == hold8, i8.product, hold8);
            end
            if (i16.done) begin
                check("w16_busy_with_done", i16.busy == 1'b0, i16.busy, 0);
                check("w16_done_expected", q16.size() != 0, q16.size(), 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("w16_product", i16.product == e.prod[31:0], i16.product, e.prod);
                    check("w16_done_edge", cyc == e.cyc, cyc, e.cyc);
                    hold16 = e.prod[31:0];
                end
            end else begin
                check("w16_product_hold", i16.product == hold16, i16.product, hold16);
            end
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [63:0] p,
                       input bit push, output int k);
        @(negedge clk);
        i8.start = 1'b1; i8.multiplicand = a; i8.multiplier = b;
        k = cyc + 1;
        if (push) q8.push_back('{p, k + lat(8, {24'd0, b})});
        @(negedge clk);
        i8.start = 1'b0; i8.multiplicand = ~a; i8.multiplier = ~b;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b, input logic [63:0] p);
        int k;
        @(negedge clk);
        i16.start = 1'b1; i16.multiplicand = a; i16.multiplier = b;
        k = cyc + 1;
        q16.push_back('{p, k + lat(16, {16'd0, b})});
        @(negedge clk);
        i16.start = 1'b0; i16.multiplicand = ~a; i16.multiplier = ~b;
        repeat (lat(16, {16'd0, b}) + 2) @(negedge clk);
    endtask

    logic [15:0] va[7] = '{16'd65535, 16'd1234, 16'd40000, 16'd32768, 16'd1, 16'd300, 16'd0};
    logic [15:0] vb[7] = '{16'd65535, 16'd5678, 16'd3,     16'd2,     16'd65535, 16'd300, 16'd777};
    logic [31:0] vp[7] = '{32'd4294836225, 32'd7006652, 32'd120000, 32'd65536,
                           32'd65535, 32'd90000, 32'd0};

    initial begin
        int k;
        int l;
        rst_n = 1'b0;
        i8.start = 1'b0;  i8.multiplicand = '0;  i8.multiplier = '0;
        i16.start = 1'b0; i16.multiplicand = '0; i16.multiplier = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", i8.busy == 1'b0, i8.busy, 0);
        check("rst_done", i8.done == 1'b0, i8.done, 0);
        check("rst_product", i8.product == 16'd0, i8.product, 0);
        check("rst_busy16", i16.busy == 1'b0, i16.busy, 0);
        check("rst_product16", i16.product == 32'd0, i16.product, 0);

        // 15x15 with busy profile: high after edges k..k+L-1, low on the done edge
        l = lat(8, 32'd15);
        go8(8'd15, 8'd15, 64'd225, 1'b1, k);
        check("busy_after_start", i8.busy == 1'b1, i8.busy, 1);
        for (int i = 1; i < l; i++) begin
            @(negedge clk);
            check("busy_run", i8.busy == 1'b1, i8.busy, 1);
        end
        @(negedge clk);
        check("busy_drop_at_done", i8.busy == 1'b0, i8.busy, 0);
        check("done_at_latency", i8.done == 1'b1, i8.done, 1);
        repeat (2) @(negedge clk);

        go8(8'd255, 8'd255, 64'd65025, 1'b1, k);
        repeat (12) @(negedge clk);
        go8(8'h37, 8'd0, 64'd0, 1'b1, k);
        repeat (12) @(negedge clk);

        // start while busy must be dropped
        go8(8'd6, 8'd7, 64'd42, 1'b1, k);
        @(negedge clk);
        i8.start = 1'b1; i8.multiplicand = 8'd3; i8.multiplier = 8'd3;
        @(negedge clk);
        i8.start = 1'b0;
        repeat (14) @(negedge clk);

        // reset mid-run discards the operation
        go8(8'd200, 8'd100, 64'd0, 1'b0, k);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", i8.busy == 1'b0, i8.busy, 0);
        check("midrst_done", i8.done == 1'b0, i8.done, 0);
        check("midrst_product", i8.product == 16'd0, i8.product, 0);
        repeat (12) @(negedge clk);
        go8(8'd9, 8'd9, 64'd81, 1'b1, k);
        repeat (12) @(negedge clk);

        // start held high; new operands accepted in the DONE cycle
        l = lat(8, 32'd11);
        @(negedge clk);
        i8.start = 1'b1; i8.multiplicand = 8'd12; i8.multiplier = 8'd11;
        k = cyc + 1;
        q8.push_back('{64'd132, k + l});
        @(negedge clk);
        i8.multiplicand = 8'd5; i8.multiplier = 8'd4;
        repeat (l) @(negedge clk);
        check("b2b_in_done_cycle", i8.done == 1'b1, i8.done, 1);
        q8.push_back('{64'd20, cyc + 1 + lat(8, 32'd4)});
        @(negedge clk);
        i8.start = 1'b0;
        check("b2b_busy_again", i8.busy == 1'b1, i8.busy, 1);
        repeat (14) @(negedge clk);

        for (int i = 0; i < 7; i++) go16(va[i], vb[i], {32'd0, vp[i]});

        repeat (4) @(negedge clk);
        check("w8_queue_drained", q8.size() == 0, q8.size(), 0);
        check("w16_queue_drained", q16.size() == 0, q16.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
